lut_gate_pipe: RTL

Parametrised successor to the single mux-built gate. WIDTH independent bit lanes, each a K-input logic function built purely from 2:1 mux trees over a 2**K-entry truth table. The truth table is runtime-reloadable over a serial config port, and results pass through one registered valid/ready stage. Used as a programmable bitwise logic unit (AND/OR/XOR/majority...) between handshaked datapath stages.

---
 rtl/lut_gate_pkg.sv | 15 +
 rtl/lut_mux_tree.sv | 26 ++
 rtl/lut_gate_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/lut_gate_pkg.sv
// Shared types and truth-table constants for the programmable bitwise logic unit.
package lut_gate_pkg;

  typedef enum logic [0:0] {ST_RUN, ST_LOAD} state_e;

  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_XOR2 = 4'b0110;
  localparam logic [7:0] TT_MAJ3 = 8'b11101000;

  function automatic int unsigned tt_len(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/lut_mux_tree.sv
// One K-input lane function: 2**K-entry truth table reduced by a binary tree of 2:1 muxes.
module lut_mux_tree #(
  parameter int unsigned K = 2
) (
  input  logic [(1<<K)-1:0] tt,
  input  logic [K-1:0]      sel,
  output logic              y
);

  // Heap-ordered nodes: node[1] is the root, node[2**K + e] holds table entry e.
  logic [(2<<K)-1:1] node;

  for (genvar e = 0; e < (1 << K); e++) begin : g_leaf
    assign node[(1<<K)+e] = tt[e];
  end

  // Depth d is steered by operand K-1-d, so the leaf level uses operand 0 (idx LSB).
  for (genvar d = 0; d < K; d++) begin : g_level
    for (genvar m = (1 << d); m < (2 << d); m++) begin : g_node
      assign node[m] = sel[K-1-d] ? node[2*m+1] : node[2*m];
    end
  end

  assign y = node[1];

endmodule

// File: rtl/lut_gate_pipe.sv
// WIDTH-lane programmable logic unit with a serially reloadable truth table and one
// registered valid/ready output stage.
module lut_gate_pipe import lut_gate_pkg::*; #(
  parameter int unsigned        WIDTH   = 8,
  parameter int unsigned        K       = 2,
  parameter logic [(1<<K)-1:0]  INIT_TT = TT_AND2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_busy
);

  localparam int unsigned TT = tt_len(K);
  localparam int unsigned CW = $clog2(TT) + 1;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [TT-1:0]     shadow_q;
  logic [TT-1:0]     shadow_d;
  logic [TT-1:0]     tt_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [WIDTH-1:0]  lane_out;
  logic              accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [K-1:0] sel;
    for (genvar k = 0; k < K; k++) begin : g_sel
      assign sel[k] = in_data[k*WIDTH+i];
    end
    lut_mux_tree #(
      .K (K)
    ) u_lane (
      .tt  (tt_q),
      .sel (sel),
      .y   (lane_out[i])
    );
  end

  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_busy  = (state_q == ST_LOAD);

  // Shadow with the current beat merged in, so the final beat lands in the same update.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[cnt_q[CW-2:0]] = cfg_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      shadow_q    <= '0;
      tt_q        <= INIT_TT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        out_data_q  <= lane_out;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_RUN: begin
          if (cfg_start && !out_valid_q) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            cnt_q <= '0;
          end else if (cfg_valid) begin
            shadow_q <= shadow_d;
            if (cnt_q == CW'(TT - 1)) begin
              tt_q    <= shadow_d;
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule
